// File: rtl/bitstream_packer_pkg.sv
// Shared constants, FSM encoding and sizing helper for the bitstream packer.
package bitstream_packer_pkg;

    localparam int OB_BITSTREAM_WIDTH  = 8;
    localparam int OB_LANES            = 3;
    localparam int OB_BYTES_PER_LANE   = 5;
    localparam int OB_WORD_BYTES       = 4;
    localparam int DEFAULT_BUF_DEPTH   = 64;
    localparam int MAX_BYTES_PER_CYCLE = OB_LANES * OB_BYTES_PER_LANE;
    localparam int LANE_COUNT_MAX      = 5;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_DRAIN  = 2'd2
    } ob_state_t;

    // Count must hold the value DEPTH itself, hence one bit more than a pointer.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bitstream_packer_if.sv
// Encoder-side burst inputs and word-stream outputs of the bitstream packer.
interface bitstream_packer_if;
    import bitstream_packer_pkg::*;

    logic [OB_BITSTREAM_WIDTH-1:0] in_bit_1_1, in_bit_1_2, in_bit_1_3, in_bit_1_4, in_bit_1_5;
    logic [OB_BITSTREAM_WIDTH-1:0] in_bit_2_1, in_bit_2_2, in_bit_2_3, in_bit_2_4, in_bit_2_5;
    logic [OB_BITSTREAM_WIDTH-1:0] in_bit_3_1, in_bit_3_2, in_bit_3_3, in_bit_3_4, in_bit_3_5;
    logic [2:0] in_flag_bitstream_1, in_flag_bitstream_2, in_flag_bitstream_3;
    logic       in_flag_last;
    logic       in_valid;
    logic       in_ready;
    logic [OB_WORD_BYTES*OB_BITSTREAM_WIDTH-1:0] out_word;
    logic [2:0] out_bytes;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;

    modport slave (
        input  in_bit_1_1, in_bit_1_2, in_bit_1_3, in_bit_1_4, in_bit_1_5,
        input  in_bit_2_1, in_bit_2_2, in_bit_2_3, in_bit_2_4, in_bit_2_5,
        input  in_bit_3_1, in_bit_3_2, in_bit_3_3, in_bit_3_4, in_bit_3_5,
        input  in_flag_bitstream_1, in_flag_bitstream_2, in_flag_bitstream_3,
        input  in_flag_last, in_valid, out_ready,
        output in_ready, out_word, out_bytes, out_last, out_valid
    );

    modport master (
        output in_bit_1_1, in_bit_1_2, in_bit_1_3, in_bit_1_4, in_bit_1_5,
        output in_bit_2_1, in_bit_2_2, in_bit_2_3, in_bit_2_4, in_bit_2_5,
        output in_bit_3_1, in_bit_3_2, in_bit_3_3, in_bit_3_4, in_bit_3_5,
        output in_flag_bitstream_1, in_flag_bitstream_2, in_flag_bitstream_3,
        output in_flag_last, in_valid, out_ready,
        input  in_ready, out_word, out_bytes, out_last, out_valid
    );

endinterface

// File: rtl/bitstream_packer_byte_ring_buffer.sv
// Byte ring buffer: writes 0..15 pre-compacted bytes per cycle, exposes a
// 4-byte read window at rd_ptr and retires 0..4 bytes per cycle.
module bitstream_packer_byte_ring_buffer
    import bitstream_packer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_BUF_DEPTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic [3:0] wr_len,
    input  logic [MAX_BYTES_PER_CYCLE-1:0][OB_BITSTREAM_WIDTH-1:0] wr_data,
    input  logic [2:0] rd_len,
    output logic [OB_WORD_BYTES-1:0][OB_BITSTREAM_WIDTH-1:0] rd_window,
    output logic [count_width(DEPTH)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = count_width(DEPTH);

    logic [OB_BITSTREAM_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [DEPTH-1:0][PTR_W-1:0] wr_off;

    // Distance of each cell from the write pointer selects its source byte.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_off
        assign wr_off[gi] = PTR_W'(gi) - wr_ptr_reg;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_off[i] < PTR_W'(wr_len)) begin
                mem[i] <= wr_data[wr_off[i][3:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(wr_len);
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(rd_len);
            count_reg  <= count_reg + CNT_W'(wr_len) - CNT_W'(rd_len);
        end
    end

    for (genvar gi = 0; gi < OB_WORD_BYTES; gi++) begin : g_rd
        assign rd_window[gi] = mem[rd_ptr_reg + PTR_W'(gi)];
    end

    assign count = count_reg;

endmodule

// File: rtl/bitstream_packer.sv
// Packs variable-length 3-lane encoder bursts into a 4-byte word stream,
// flushing a final partial word (or empty terminator) on the last burst.
module bitstream_packer
    import bitstream_packer_pkg::*;
#(
    parameter int OB_BUF_DEPTH = DEFAULT_BUF_DEPTH
) (
    input  logic ob_clk,
    input  logic ob_reset,
    bitstream_packer_if.slave bus,
    output logic ob_overflow,
    output logic ob_error
);
    localparam int CNT_W  = count_width(OB_BUF_DEPTH);
    localparam int WORD_W = OB_WORD_BYTES * OB_BITSTREAM_WIDTH;

    logic [OB_LANES-1:0][OB_BYTES_PER_LANE-1:0][OB_BITSTREAM_WIDTH-1:0] lane_bytes;
    logic [OB_LANES-1:0][2:0] lane_cnt_raw;
    logic [OB_LANES-1:0]      lane_bad;
    logic [MAX_BYTES_PER_CYCLE-1:0][OB_BITSTREAM_WIDTH-1:0] compact;
    logic [3:0] lane_len;
    logic [3:0] lane_off;
    logic [3:0] burst_len;
    logic [3:0] wr_len;

    ob_state_t state_reg, state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] free_space;
    logic in_ready_int;
    logic accept;
    logic load_ok;
    logic do_load;
    logic load_last;
    logic [2:0] load_len;
    logic [2:0] rd_len;
    logic [OB_WORD_BYTES-1:0][OB_BITSTREAM_WIDTH-1:0] rd_window;
    logic [WORD_W-1:0] load_word;

    logic [WORD_W-1:0] out_word_reg;
    logic [2:0] out_bytes_reg;
    logic out_last_reg;
    logic out_valid_reg;
    logic overflow_reg;
    logic error_reg;

    assign lane_bytes = {
        bus.in_bit_3_5, bus.in_bit_3_4, bus.in_bit_3_3, bus.in_bit_3_2, bus.in_bit_3_1,
        bus.in_bit_2_5, bus.in_bit_2_4, bus.in_bit_2_3, bus.in_bit_2_2, bus.in_bit_2_1,
        bus.in_bit_1_5, bus.in_bit_1_4, bus.in_bit_1_3, bus.in_bit_1_2, bus.in_bit_1_1};
    assign lane_cnt_raw = {bus.in_flag_bitstream_3, bus.in_flag_bitstream_2, bus.in_flag_bitstream_1};

    for (genvar gi = 0; gi < OB_LANES; gi++) begin : g_lane
        assign lane_bad[gi] = lane_cnt_raw[gi] > 3'(LANE_COUNT_MAX);
    end

    // Lanes are concatenated back to back; an illegal lane contributes nothing.
    always_comb begin
        compact  = '0;
        lane_off = 4'd0;
        lane_len = 4'd0;
        for (int l = 0; l < OB_LANES; l++) begin
            lane_len = lane_bad[l] ? 4'd0 : {1'b0, lane_cnt_raw[l]};
            for (int b = 0; b < OB_BYTES_PER_LANE; b++) begin
                if (4'(b) < lane_len) begin
                    compact[lane_off + 4'(b)] = lane_bytes[l][b];
                end
            end
            lane_off = lane_off + lane_len;
        end
        burst_len = lane_off;
    end

    assign free_space   = CNT_W'(OB_BUF_DEPTH) - count;
    assign in_ready_int = (state_reg == ST_ACCEPT) && (free_space >= CNT_W'(MAX_BYTES_PER_CYCLE));
    assign accept       = bus.in_valid && in_ready_int;
    assign wr_len       = accept ? burst_len : 4'd0;
    assign load_ok      = !out_valid_reg || bus.out_ready;
    assign rd_len       = do_load ? load_len : 3'd0;

    bitstream_packer_byte_ring_buffer #(
        .DEPTH (OB_BUF_DEPTH)
    ) u_ring (
        .clk       (ob_clk),
        .rst_n     (ob_reset),
        .wr_len    (wr_len),
        .wr_data   (compact),
        .rd_len    (rd_len),
        .rd_window (rd_window),
        .count     (count)
    );

    always_ff @(posedge ob_clk or negedge ob_reset) begin
        if (!ob_reset) begin
            state_reg <= ST_ACCEPT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        do_load    = 1'b0;
        load_len   = 3'd0;
        load_last  = 1'b0;
        unique case (state_reg)
            ST_ACCEPT: begin
                if (load_ok && count >= CNT_W'(OB_WORD_BYTES)) begin
                    do_load  = 1'b1;
                    load_len = 3'(OB_WORD_BYTES);
                end
                if (accept && bus.in_flag_last) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (load_ok) begin
                    do_load = 1'b1;
                    if (count > CNT_W'(OB_WORD_BYTES)) begin
                        load_len = 3'(OB_WORD_BYTES);
                    end else begin
                        // Remainder (possibly zero bytes) closes the stream.
                        load_len   = count[2:0];
                        load_last  = 1'b1;
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_valid_reg && bus.out_ready) begin
                    state_next = ST_ACCEPT;
                end
            end
            default: state_next = ST_ACCEPT;
        endcase
    end

    for (genvar gi = 0; gi < OB_WORD_BYTES; gi++) begin : g_word
        assign load_word[WORD_W-1-gi*OB_BITSTREAM_WIDTH -: OB_BITSTREAM_WIDTH] =
            (3'(gi) < load_len) ? rd_window[gi] : '0;
    end

    always_ff @(posedge ob_clk or negedge ob_reset) begin
        if (!ob_reset) begin
            out_word_reg  <= '0;
            out_bytes_reg <= '0;
            out_last_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            if (load_ok) begin
                out_valid_reg <= do_load;
                if (do_load) begin
                    out_word_reg  <= load_word;
                    out_bytes_reg <= load_len;
                    out_last_reg  <= load_last;
                end
            end
            if (bus.in_valid && !in_ready_int) begin
                overflow_reg <= 1'b1;
            end
            if (accept && |lane_bad) begin
                error_reg <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_word  = out_word_reg;
    assign bus.out_bytes = out_bytes_reg;
    assign bus.out_last  = out_last_reg;
    assign bus.out_valid = out_valid_reg;
    assign ob_overflow   = overflow_reg;
    assign ob_error      = error_reg;

endmodule

// File: tb/tb_bitstream_packer.sv
// Directed bench for bitstream_packer: bursts feed a byte model that queues
// expected words; a monitor pops and compares on every output handshake.
module tb_bitstream_packer;
    import bitstream_packer_pkg::*;

    typedef struct {
        logic [31:0] word;
        logic [2:0]  nbytes;
        logic        last;
    } exp_t;

    logic ob_clk = 1'b0;
    logic ob_reset;
    logic ob_overflow;
    logic ob_error;
    logic [7:0] drv_bit [3][5];
    logic [2:0] drv_cnt [3];
    logic [31:0] held_req;

    exp_t exp_q[$];
    exp_t mon_e;
    logic [7:0] pend_q[$];
    int total = 0;
    int bad = 0;
    int seq = 1;

    bitstream_packer_if bus();

    assign bus.in_bit_1_1 = drv_bit[0][0]; assign bus.in_bit_1_2 = drv_bit[0][1]; assign bus.in_bit_1_3 = drv_bit[0][2];
    assign bus.in_bit_1_4 = drv_bit[0][3]; assign bus.in_bit_1_5 = drv_bit[0][4];
    assign bus.in_bit_2_1 = drv_bit[1][0]; assign bus.in_bit_2_2 = drv_bit[1][1]; assign bus.in_bit_2_3 = drv_bit[1][2];
    assign bus.in_bit_2_4 = drv_bit[1][3]; assign bus.in_bit_2_5 = drv_bit[1][4];
    assign bus.in_bit_3_1 = drv_bit[2][0]; assign bus.in_bit_3_2 = drv_bit[2][1]; assign bus.in_bit_3_3 = drv_bit[2][2];
    assign bus.in_bit_3_4 = drv_bit[2][3]; assign bus.in_bit_3_5 = drv_bit[2][4];
    assign bus.in_flag_bitstream_1 = drv_cnt[0];
    assign bus.in_flag_bitstream_2 = drv_cnt[1];
    assign bus.in_flag_bitstream_3 = drv_cnt[2];

    bitstream_packer dut (
        .ob_clk      (ob_clk),
        .ob_reset    (ob_reset),
        .bus         (bus),
        .ob_overflow (ob_overflow),
        .ob_error    (ob_error)
    );

    always #5 ob_clk = ~ob_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic exp_t take_word(input int n, input logic last);
        exp_t e;
        e.word = '0;
        for (int i = 0; i < n; i++) e.word[31-8*i -: 8] = pend_q.pop_front();
        e.nbytes = 3'(n);
        e.last = last;
        return e;
    endfunction

    task automatic set_pattern(input int n1, input int n2, input int n3);
        drv_cnt[0] = 3'(n1); drv_cnt[1] = 3'(n2); drv_cnt[2] = 3'(n3);
        for (int l = 0; l < 3; l++)
            for (int b = 0; b < 5; b++) drv_bit[l][b] = 8'(8'h11 + 16 * l + b);
    endtask

    task automatic set_seq(input int n1, input int n2, input int n3);
        drv_cnt[0] = 3'(n1); drv_cnt[1] = 3'(n2); drv_cnt[2] = 3'(n3);
        for (int l = 0; l < 3; l++)
            for (int b = 0; b < 5; b++) begin
                drv_bit[l][b] = 8'(seq);
                seq++;
            end
    endtask

    // Issue one burst (waiting for in_ready) and queue the words it implies.
    task automatic send(input logic last);
        int guard = 0;
        int n;
        while (!bus.in_ready && guard < 300) begin
            @(posedge ob_clk); #1;
            guard++;
        end
        if (!bus.in_ready) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready got 0 required 1");
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_flag_last = last;
        @(posedge ob_clk); #1;
        bus.in_valid = 1'b0;
        bus.in_flag_last = 1'b0;
        $display("burst %0d/%0d/%0d last=%0b", drv_cnt[0], drv_cnt[1], drv_cnt[2], last);
        for (int l = 0; l < 3; l++) begin
            n = (drv_cnt[l] > 3'd5) ? 0 : int'(drv_cnt[l]);
            for (int b = 0; b < n; b++) pend_q.push_back(drv_bit[l][b]);
        end
        while (pend_q.size() >= 4) exp_q.push_back(take_word(4, 1'b0));
        if (last) exp_q.push_back(take_word(pend_q.size(), 1'b1));
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && guard < 500) begin
            @(posedge ob_clk); #1;
            guard++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    always @(negedge ob_clk) begin
        if (ob_reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_word: got %08h required none", bus.out_word);
            end else begin
                mon_e = exp_q.pop_front();
                $display("word %08h bytes %0d last %0b", bus.out_word, bus.out_bytes, bus.out_last);
                chk("out_word", bus.out_word, mon_e.word);
                chk("out_bytes", 32'(bus.out_bytes), 32'(mon_e.nbytes));
                chk("out_last", 32'(bus.out_last), 32'(mon_e.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_flag_last = 1'b0;
        bus.out_ready = 1'b0;
        set_pattern(0, 0, 0);
        ob_reset = 1'b1;
        #2 ob_reset = 1'b0;
        repeat (3) @(posedge ob_clk);
        #1;
        chk("reset_out_valid", 32'(bus.out_valid), 0);
        chk("reset_out_word", bus.out_word, 0);
        chk("reset_out_bytes", 32'(bus.out_bytes), 0);
        chk("reset_out_last", 32'(bus.out_last), 0);
        chk("reset_overflow", 32'(ob_overflow), 0);
        chk("reset_error", 32'(ob_error), 0);
        ob_reset = 1'b1;
        @(posedge ob_clk); #1;
        chk("reset_in_ready", 32'(bus.in_ready), 1);

        // Compaction: 11 12 | - | 31 32 33 with last.
        bus.out_ready = 1'b1;
        set_pattern(2, 0, 3);
        send(1'b1);
        wait_drain();
        chk("after_last_in_ready", 32'(bus.in_ready), 1);

        // Pointer wrap: 93 bytes through a 64-byte ring.
        for (int i = 0; i < 12; i++) begin
            set_seq(i % 6, (i + 2) % 6, (i + 4) % 6);
            send(1'b0);
        end
        set_seq(1, 2, 0);
        send(1'b1);
        wait_drain();

        // Backpressure: four full bursts with the consumer stalled.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_seq(5, 5, 5);
            send(1'b0);
        end
        chk("bp_in_ready_low", 32'(bus.in_ready), 0);
        chk("bp_overflow", 32'(ob_overflow), 0);
        held_req = exp_q[0].word;
        repeat (5) @(posedge ob_clk);
        #1;
        chk("bp_held_valid", 32'(bus.out_valid), 1);
        chk("bp_held_word", bus.out_word, held_req);
        bus.out_ready = 1'b1;
        set_seq(5, 5, 5);
        send(1'b1);
        wait_drain();

        // Overflow: a burst (with last) presented while in_ready is low is dropped.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_seq(5, 5, 5);
            send(1'b0);
        end
        set_seq(5, 5, 5);
        bus.in_valid = 1'b1;
        bus.in_flag_last = 1'b1;
        @(posedge ob_clk); #1;
        bus.in_valid = 1'b0;
        bus.in_flag_last = 1'b0;
        chk("ovf_flag", 32'(ob_overflow), 1);
        bus.out_ready = 1'b1;
        set_seq(1, 0, 0);
        send(1'b1);
        wait_drain();
        chk("ovf_sticky", 32'(ob_overflow), 1);

        // Last with an empty buffer yields a zero-byte terminator.
        set_pattern(0, 0, 0);
        send(1'b1);
        wait_drain();
        chk("empty_last_in_ready", 32'(bus.in_ready), 1);

        // Illegal lane count: lane 2 dropped.
        set_pattern(2, 7, 1);
        send(1'b1);
        chk("illegal_error", 32'(ob_error), 1);
        wait_drain();

        // Reset mid-stream with 10 bytes buffered.
        bus.out_ready = 1'b0;
        set_seq(5, 5, 0);
        send(1'b0);
        repeat (2) @(posedge ob_clk);
        #1;
        chk("mid_valid_before_reset", 32'(bus.out_valid), 1);
        #2 ob_reset = 1'b0;
        #1;
        chk("mid_async_valid", 32'(bus.out_valid), 0);
        chk("mid_async_word", bus.out_word, 0);
        exp_q.delete();
        pend_q.delete();
        repeat (2) @(posedge ob_clk);
        #1;
        ob_reset = 1'b1;
        chk("mid_overflow_clr", 32'(ob_overflow), 0);
        chk("mid_error_clr", 32'(ob_error), 0);
        bus.out_ready = 1'b1;
        set_seq(1, 1, 1);
        send(1'b1);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bitstream_packer.md
Name: bitstream_packer

Overview:
- Sits directly downstream of entropy_encoder and consumes its per-cycle burst of up to 15 bitstream bytes (3 lanes x 5 bytes, each lane with a 3-bit byte count).
- Compacts the variable-length burst into a ring buffer of bytes.
- Emits a fixed-width word stream with valid/ready handshake, and flushes a final partial word when OUT_FLAG_LAST arrives.

Parameters:
- OB_BITSTREAM_WIDTH, 8, byte width; must match the encoder output byte width.
- OB_LANES, 3, number of input lanes.
- OB_BYTES_PER_LANE, 5, maximum bytes per lane per cycle.
- OB_BUF_DEPTH, 64, ring-buffer depth in bytes; power of two, at least 2*OB_LANES*OB_BYTES_PER_LANE.
- OB_WORD_BYTES, 4, bytes per output word.

Ports:
- ob_clk  in  1  clock, rising edge.
- ob_reset  in  1  asynchronous, active-low reset.
- in_bit_L_B  in  8 each  byte B (1..5) of lane L (1..3), 15 ports total; connect to OUT_BIT_L_B.
- in_flag_bitstream_L  in  3 each  number of valid bytes in lane L (0..5); connect to OUT_FLAG_BITSTREAM_L.
- in_flag_last  in  1  final input cycle marker; connect to OUT_FLAG_LAST.
- in_valid  in  1  input burst valid this cycle.
- in_ready  out  1  packer can accept a full 15-byte burst.
- out_word  out  OB_WORD_BYTES*8  packed bytes; the first byte in stream order is in the MSBs.
- out_bytes  out  3  valid bytes in out_word (0..4), MSB-aligned.
- out_last  out  1  this is the final word of the stream.
- out_valid  out  1  out_word, out_bytes and out_last are valid.
- out_ready  in  1  consumer accepts the word.
- ob_overflow  out  1  sticky: a burst was presented while in_ready=0.
- ob_error  out  1  sticky: a lane count of 6 or 7 was received.

Behaviour:
- Reset (ob_reset=0, asynchronous): pointers, count and FSM cleared; state ACCEPT.
  - Outputs at reset: out_valid=0, out_word=0, out_bytes=0, out_last=0, ob_overflow=0, ob_error=0.
  - in_ready=1 after reset deasserts.
  - Reset mid-stream discards all buffered bytes.
- Input compaction when in_valid=1 and the burst is accepted:
  - Bytes are written in stream order: lane1 bytes 1..n1, then lane2 bytes 1..n2, then lane3 bytes 1..n3.
  - Total written is n1+n2+n3 (0..15). wr_ptr advances by that total, modulo OB_BUF_DEPTH.
  - A lane count above 5 sets ob_error and that lane contributes 0 bytes.
- in_ready = (state==ACCEPT) && (OB_BUF_DEPTH - count >= 15). It is computed from registered state only.
- Overflow: in_valid=1 while in_ready=0 drops the burst, sets ob_overflow and leaves pointers unchanged.
  - in_flag_last in a dropped burst is also ignored.
- Output register loads whenever out_valid==0 or out_ready==1, using the registered count:
  - ACCEPT, count>=4: load 4 bytes from rd_ptr; out_bytes=4, out_last=0, out_valid=1; rd_ptr+=4.
  - FLUSH, count>=4 and count>4: same as the ACCEPT case, out_last=0.
  - FLUSH, count<=4: load the remaining count bytes (0..4), MSB-aligned with zero fill; out_last=1, out_valid=1; go to DRAIN.
    - count==0 yields a terminator word with out_bytes=0.
  - Otherwise: out_valid falls to 0 when the held word is accepted.
- Stability: while out_valid=1 and out_ready=0, out_word, out_bytes and out_last are held stable.
- FSM:
  - ACCEPT -> FLUSH on an accepted burst with in_flag_last=1; the bytes of that burst are included.
  - FLUSH: in_ready=0.
  - DRAIN -> ACCEPT when the out_last word handshakes (out_valid && out_ready). Pointers are then equal and count=0.
- Latency: bytes accepted at edge k can appear on out_word after edge k+1 at the earliest.
- Simultaneous write and read in one cycle: count_next = count + written - read. Both pointers wrap modulo depth.
- Count width is log2(OB_BUF_DEPTH)+1. Count never exceeds OB_BUF_DEPTH.
- in_flag_last with in_valid=0 is ignored.

Decomposition:
- Package bitstream_packer_pkg holds:
  - MAX_BYTES_PER_CYCLE = OB_LANES*OB_BYTES_PER_LANE (15);
  - lane-count legal maximum (5);
  - FSM state encoding ACCEPT/FLUSH/DRAIN;
  - the pointer/count width function.
- Sub-module byte_ring_buffer: multi-byte write (0..15 per cycle, pre-compacted) and 4-byte read window with wrapping pointers.
  - The top level holds the lane compaction mux, the FSM, the output register and the sticky flags.

Test Plan:
- Reset: hold ob_reset=0 for 3 cycles, then release -> out_valid=0, in_ready=1, ob_overflow=0, ob_error=0.
- Compaction and wrap: counts (2,0,3), bytes 0x11,0x12 / 0x31..0x33, out_ready=1 -> words {0x11,0x12,0x31,0x32}, then after last {0x33} with out_bytes=1, out_last=1.
  - Also repeat 13 bursts to force pointer wrap; the compared byte stream must be identical to the input order.
- Backpressure: out_ready=0 with five 15-byte bursts -> in_ready drops to 0 once free<15, ob_overflow stays 0.
  - The held out_word stays constant until out_ready=1, and every byte is later delivered in order.
- Overflow: force in_valid=1 while in_ready=0 -> ob_overflow=1 sticky, byte count delivered unchanged by the dropped burst.
- Last with empty buffer: single burst counts (0,0,0), in_flag_last=1 -> exactly one word with out_bytes=0, out_last=1, then back to ACCEPT with in_ready=1.
- Illegal count and reset mid-stream: lane2 count=7 -> ob_error=1 and lane2 bytes are dropped.
  - Assert ob_reset=0 with 10 bytes buffered -> out_valid=0 immediately (asynchronous), and no stale bytes appear after release.
